spi_flash_read_ctrl: RTL and testbench
======================================

Name: spi_flash_read_ctrl

Overview:
Sequencer that owns the SPI flash pins and performs standard READ (0x03) transactions. On a start request it drives the command byte, a 24-bit address, and a programmable number of data bytes. Read data is streamed out one byte at a time with a valid strobe. It sits beside the LED driver in the flash top level, in the position of the ID reader, and drives sck/cs/sdo directly.

Parameters:
CLK_DIV, 2, sck half-period in clk12MHz cycles (>=1); default gives 3 MHz sck
CS_GAP, 4, minimum cs-high cycles between transactions (>=1)

Ports:
clk12MHz  input  1  system clock, 12 MHz
rst  input  1  asynchronous reset, active-high
start  input  1  transaction request, sampled only in IDLE
addr  input  24  flash byte address, captured on accepted start
len  input  8  byte count, captured on accepted start; 0 means 256
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse at end of transaction
rd_data  output  8  last received byte, MSB first
rd_valid  output  1  one-cycle pulse when rd_data updates
sck  output  1  SPI clock, mode 0 (idles low)
cs  output  1  flash chip select, active-low
sdo  output  1  MOSI
sdi  input  1  MISO

Behaviour:
- Reset (async, immediate): cs=1, sck=0, sdo=0, busy=0, done=0, rd_valid=0, rd_data=0x00, state=IDLE. Counters cleared.
- Reset mid-transaction aborts it: cs rises asynchronously, no done pulse, no partial rd_valid.
- SPI mode 0, MSB first. sdo changes only while sck is low (at the falling edge, or at CS_SETUP for the first bit). sdi is sampled on the clk12MHz edge where sck rises.
- sck toggles every CLK_DIV cycles inside shift states only. Each bit takes 2*CLK_DIV cycles.
- States:
  - IDLE: cs=1, sck=0. When start=1, capture addr and len, then go to CS_SETUP with busy=1 next cycle. While busy=1, start is ignored.
  - CS_SETUP: cs=0, sdo=bit7 of 0x03. Wait CLK_DIV cycles, then go to SHIFT_CMD.
  - SHIFT_CMD: 8 bits of 0x03, then SHIFT_ADDR.
  - SHIFT_ADDR: 24 bits, addr[23] first, then SHIFT_DATA.
  - SHIFT_DATA: 8*N bits with sdo=0 (N=len, or 256 when len=0). After each 8th sample, rd_data takes the assembled byte and rd_valid pulses on the next cycle. After byte N, go to CS_HOLD.
  - CS_HOLD: sck=0, cs=0 for CLK_DIV cycles after the final falling edge, then CS_GAP_ST.
  - CS_GAP_ST: cs=1 for CS_GAP cycles, then IDLE. On entry to IDLE, done=1 for one cycle and busy=0 in the same cycle.
- start asserted in the same cycle as done: it is accepted, because the state is IDLE. The minimum cs-high time is then CS_GAP+1 cycles.
- The bit counter spans 6 bits. The byte counter spans 9 bits so N=256 does not wrap. The address is not incremented internally; the flash auto-increments it.
- The first data byte corresponds to the 33rd sck rising edge.
- Transaction length in clk12MHz cycles, from start acceptance to done: 1 + CLK_DIV + 2*CLK_DIV*(32+8N) + CLK_DIV + CS_GAP (±1 for registering).
- rd_valid pulses never occur outside SHIFT_DATA/CS_HOLD. There is exactly one pulse per byte.

Test Plan:
- Reset: assert rst for 3 cycles mid-idle -> cs=1, sck=0, busy=0, rd_data=0x00; release, no activity without start.
- Single byte: start with addr=0x123456, len=1, flash model returns 0xA5 -> sdo stream is 0x03,0x12,0x34,0x56; 40 sck rising edges; one rd_valid with rd_data=0xA5; one done; cs high for >=CS_GAP cycles.
- Burst: len=4, model returns 0x01,0x02,0x03,0x04 -> four rd_valid pulses in order, each 16*CLK_DIV cycles apart; busy high throughout; done once.
- len=0: model returns an incrementing pattern -> exactly 256 rd_valid pulses, the last with rd_data=0xFF; 2080 sck edges; no counter wrap.
- Reset mid-data: assert rst during byte 2 of len=4 -> cs=1 in the same cycle (async), no done, no further rd_valid; the next start runs a clean full transaction.
- Start handling: start pulsed while busy -> ignored; start held in the done cycle -> a second transaction begins with cs high for CS_GAP+1 cycles; sck period equals 2*CLK_DIV with CLK_DIV=1 and CLK_DIV=3.

Source files
------------

// File: rtl/spi_flash_read_ctrl.sv
// SPI flash READ (0x03) sequencer.
// Owns the flash pins. On an accepted start it sends the command byte and a 24-bit address,
// then clocks in len bytes (0 means 256). Each byte is presented on rd_data with a one-cycle
// rd_valid strobe.
//
// Ports:
//   clk12MHz  - system clock (12 MHz)
//   rst       - asynchronous reset, active-high
//   start     - transaction request, only sampled in idle
//   addr      - flash byte address, captured on an accepted start
//   len       - byte count, captured on an accepted start (0 = 256)
//   busy      - high from the cycle after an accepted start until done
//   done      - one-cycle pulse when the transaction ends
//   rd_data   - last received byte (MSB first on the wire)
//   rd_valid  - one-cycle pulse when rd_data updates
//   sck       - SPI clock, mode 0 (idles low)
//   cs        - chip select, active-low
//   sdo       - MOSI
//   sdi       - MISO
module spi_flash_read_ctrl #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic        clk12MHz,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [7:0]  len,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        sck,
  output logic        cs,
  output logic        sdo,
  input  logic        sdi
);

  localparam int unsigned CntMax = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(CS_GAP - 1);
  localparam logic [7:0] ReadCmd = 8'h03;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StShiftCmd,
    StShiftAddr,
    StShiftData,
    StCsHold,
    StCsGap
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;       // half-period divider, reused for hold and gap timing
  logic [31:0]     tx_q;        // command + address, shifted out MSB first
  logic [7:0]      rx_q;
  logic [5:0]      bit_cnt_q;   // rising edges within the current phase / data byte
  logic [8:0]      byte_cnt_q;  // 9 bits so a 256-byte read does not wrap
  logic [7:0]      len_q;
  logic            busy_q;
  logic            done_q;
  logic [7:0]      rd_data_q;
  logic            rd_valid_q;
  logic            sck_q;
  logic            cs_q;
  logic            sdo_q;

  logic [8:0] n_bytes;
  logic       div_last;

  assign n_bytes  = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
  assign div_last = (cnt_q == DivLast);

  always_ff @(posedge clk12MHz or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      sdo_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cs_q  <= 1'b1;
          sck_q <= 1'b0;
          if (start) begin
            tx_q       <= {ReadCmd, addr};
            len_q      <= len;
            sdo_q      <= ReadCmd[7];
            cs_q       <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            state_q    <= StCsSetup;
          end
        end
        StCsSetup: begin
          if (div_last) begin
            cnt_q   <= '0;
            state_q <= StShiftCmd;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StShiftCmd, StShiftAddr, StShiftData: begin
          if (!div_last) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              // Rising sck edge: sample MISO.
              rx_q <= {rx_q[6:0], sdi};
              if (state_q == StShiftData && bit_cnt_q == 6'd7) begin
                bit_cnt_q  <= '0;
                byte_cnt_q <= byte_cnt_q + 9'd1;
                rd_data_q  <= {rx_q[6:0], sdi};
                rd_valid_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
              end
            end else begin
              // Falling sck edge: advance MOSI; zeros follow the address.
              tx_q  <= {tx_q[30:0], 1'b0};
              sdo_q <= tx_q[30];
              if (state_q == StShiftCmd && bit_cnt_q == 6'd8) begin
                bit_cnt_q <= '0;
                state_q   <= StShiftAddr;
              end else if (state_q == StShiftAddr && bit_cnt_q == 6'd24) begin
                bit_cnt_q <= '0;
                state_q   <= StShiftData;
              end else if (state_q == StShiftData && bit_cnt_q == 6'd0 &&
                           byte_cnt_q == n_bytes) begin
                state_q <= StCsHold;
              end
            end
          end
        end
        StCsHold: begin
          sck_q <= 1'b0;
          if (div_last) begin
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            state_q <= StCsGap;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StCsGap: begin
          if (cnt_q == GapLast) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign sck      = sck_q;
  assign cs       = cs_q;
  assign sdo      = sdo_q;

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// Self-checking bench for spi_flash_read_ctrl: behavioural flash model, byte scoreboard,
// table of read transactions plus hand sequences for reset, start handling and CLK_DIV.
module tb_spi_flash_read_ctrl;

  localparam int unsigned ClkDiv = 2;
  localparam int unsigned CsGap  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] addr;
  logic [7:0]  len;
  logic        busy, done, rd_valid, sck, cs, sdo;
  logic [7:0]  rd_data;
  logic        sdi = 1'b0;

  logic        start_s;
  logic        busy1, done1, rdv1, sck1, cs1, sdo1;
  logic [7:0]  rdd1;
  logic        busy3, done3, rdv3, sck3, cs3, sdo3;
  logic [7:0]  rdd3;

  always #5 clk = ~clk;

  spi_flash_read_ctrl #(.CLK_DIV(ClkDiv), .CS_GAP(CsGap)) u_dut (
    .clk12MHz(clk), .rst(rst), .start(start), .addr(addr), .len(len), .busy(busy),
    .done(done), .rd_data(rd_data), .rd_valid(rd_valid), .sck(sck), .cs(cs), .sdo(sdo),
    .sdi(sdi)
  );

  spi_flash_read_ctrl #(.CLK_DIV(1), .CS_GAP(CsGap)) u_div1 (
    .clk12MHz(clk), .rst(rst), .start(start_s), .addr(24'h000000), .len(8'd1), .busy(busy1),
    .done(done1), .rd_data(rdd1), .rd_valid(rdv1), .sck(sck1), .cs(cs1), .sdo(sdo1),
    .sdi(1'b0)
  );

  spi_flash_read_ctrl #(.CLK_DIV(3), .CS_GAP(CsGap)) u_div3 (
    .clk12MHz(clk), .rst(rst), .start(start_s), .addr(24'h000000), .len(8'd1), .busy(busy3),
    .done(done3), .rd_data(rdd3), .rd_valid(rdv3), .sck(sck3), .cs(cs3), .sdo(sdo3),
    .sdi(1'b0)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  // Flash model: captures cmd+addr on rising sck, drives data on falling sck.
  logic [7:0]  flash_data [256];
  logic [31:0] hdr_sh = '0;
  logic [31:0] hdr_q [$];
  int          bit_idx   = 0;
  int          sck_rises = 0;
  int          flash_d;

  always @(posedge sck or negedge sck or posedge cs) begin
    if (cs) begin
      bit_idx = 0;
      sdi     = 1'b0;
    end else if (sck) begin
      if (bit_idx < 32) begin
        hdr_sh = {hdr_sh[30:0], sdo};
        if (bit_idx == 31) hdr_q.push_back(hdr_sh);
      end
      bit_idx++;
      sck_rises++;
    end else if (bit_idx >= 32) begin
      flash_d = bit_idx - 32;
      sdi     = flash_data[8'((flash_d / 8) % 256)][3'(7 - (flash_d % 8))];
    end
  end

  // Scoreboard and output monitor.
  logic [7:0] exp_q [$];
  int         cyc_cnt    = 0;
  int         rv_count   = 0;
  int         done_count = 0;
  int         rv_outside = 0;
  int         rv_time [1024];
  logic [7:0] last_rd    = '0;

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    if (done) done_count++;
    if (rd_valid) begin
      rv_time[rv_count % 1024] = cyc_cnt;
      rv_count++;
      last_rd = rd_data;
      if (cs) rv_outside++;
      check("sb_has_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rd_data", rd_data, exp_q.pop_front());
    end
  end

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  len;
    logic [7:0]  base;
    logic [7:0]  step;
    logic [31:0] exp_hdr;
    int          exp_edges;
    int          exp_cycles;
    logic [7:0]  exp_last;
    int          exp_bytes;
  } vec_t;

  vec_t vecs [4];

  task automatic pop_hdr(output logic [31:0] h);
    if (hdr_q.size() > 0) h = hdr_q.pop_front();
    else h = 32'h0;
  endtask

  task automatic run_vec(input vec_t v);
    int rv0, dn0, ed0, cyc, bad;
    logic busy_drop;
    logic [31:0] h;
    for (int i = 0; i < 256; i++) flash_data[i] = v.base + 8'(i) * v.step;
    for (int i = 0; i < v.exp_bytes; i++) exp_q.push_back(flash_data[i]);
    rv0 = rv_count; dn0 = done_count; ed0 = sck_rises;
    @(negedge clk); addr = v.addr; len = v.len; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1);
    cyc = 1; busy_drop = 1'b0;
    while (!done && cyc < 20000) begin
      if (!busy) busy_drop = 1'b1;
      @(negedge clk); cyc++;
    end
    check("txn_cycles", cyc, v.exp_cycles);
    check("busy_in_done_cycle", busy, 0);
    check("busy_held", busy_drop, 0);
    repeat (8) @(negedge clk);
    check("done_pulses", done_count - dn0, 1);
    check("sck_rises", sck_rises - ed0, v.exp_edges);
    check("rd_valid_count", rv_count - rv0, v.exp_bytes);
    check("last_rd_data", last_rd, v.exp_last);
    check("cs_idle", cs, 1);
    pop_hdr(h);
    check("header", h, v.exp_hdr);
    check("sb_drained", exp_q.size(), 0);
    bad = 0;
    for (int i = 1; i < v.exp_bytes; i++)
      if (rv_time[(rv0 + i) % 1024] - rv_time[(rv0 + i - 1) % 1024] != 16 * ClkDiv) bad++;
    check("rd_valid_spacing", bad, 0);
  endtask

  initial begin
    int rv0, dn0, ed0, cyc, run, gap, dseen;
    logic bad;
    logic [31:0] h;

    rst = 1'b1; start = 1'b0; start_s = 1'b0; addr = '0; len = '0;
    vecs[0] = '{addr: 24'h123456, len: 8'd1, base: 8'hA5, step: 8'h00, exp_hdr: 32'h03123456,
                exp_edges: 40, exp_cycles: 169, exp_last: 8'hA5, exp_bytes: 1};
    vecs[1] = '{addr: 24'hABCDEF, len: 8'd4, base: 8'h01, step: 8'h01, exp_hdr: 32'h03ABCDEF,
                exp_edges: 64, exp_cycles: 265, exp_last: 8'h04, exp_bytes: 4};
    vecs[2] = '{addr: 24'h000000, len: 8'd0, base: 8'h00, step: 8'h01, exp_hdr: 32'h03000000,
                exp_edges: 2080, exp_cycles: 8329, exp_last: 8'hFF, exp_bytes: 256};
    vecs[3] = '{addr: 24'hFFFFFF, len: 8'd2, base: 8'h80, step: 8'h11, exp_hdr: 32'h03FFFFFF,
                exp_edges: 48, exp_cycles: 201, exp_last: 8'h91, exp_bytes: 2};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Reset while idle.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    rst = 1'b0;
    ed0 = sck_rises; bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!cs || busy || done) bad = 1'b1;
    end
    check("idle_no_activity", bad, 0);
    check("idle_no_sck", sck_rises - ed0, 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Reset during the second data byte of a 4-byte read.
    for (int i = 0; i < 256; i++) flash_data[i] = 8'h40 + 8'(i);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h40 + 8'(i));
    rv0 = rv_count; dn0 = done_count;
    @(negedge clk); addr = 24'h0A0B0C; len = 8'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (rv_count == rv0 && cyc < 2000) begin @(negedge clk); cyc++; end
    repeat (10) @(negedge clk);
    check("first_byte_before_reset", rv_count - rv0, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_cs_async", cs, 1);
    check("abort_sck", sck, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    check("abort_rd_data", rd_data, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("abort_rd_valid_count", rv_count - rv0, 1);
    check("abort_no_done", done_count - dn0, 0);
    check("abort_sb_left", exp_q.size(), 3);
    exp_q.delete();
    hdr_q.delete();
    run_vec(vecs[1]);

    // Start while busy is ignored; start held into the done cycle chains a transaction.
    for (int i = 0; i < 256; i++) flash_data[i] = 8'h3C;
    exp_q.push_back(8'h3C);
    rv0 = rv_count; dn0 = done_count; ed0 = sck_rises;
    @(negedge clk); addr = 24'h111111; len = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    addr = 24'h222222; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    addr = 24'h333333; start = 1'b1;
    exp_q.push_back(8'h3C);
    cyc = 0; dseen = 0; run = 0; gap = 0;
    while (dseen < 2 && cyc < 1000) begin
      @(negedge clk); cyc++;
      if (cs) run++;
      else begin
        if (run > 0) gap = run;
        run = 0;
      end
      if (done) dseen++;
      else if (dseen == 1 && start) start = 1'b0;
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("chain_done_pulses", done_count - dn0, 2);
    pop_hdr(h);
    check("chain_hdr1", h, 32'h03111111);
    pop_hdr(h);
    check("chain_hdr2", h, 32'h03333333);
    check("chain_no_extra_hdr", hdr_q.size(), 0);
    check("chain_sck_rises", sck_rises - ed0, 80);
    check("chain_rd_valid_count", rv_count - rv0, 2);
    check("chain_cs_high_cycles", gap, CsGap + 1);
    check("chain_sb_drained", exp_q.size(), 0);

    // sck period and transaction length with CLK_DIV=1 and CLK_DIV=3.
    begin
      int r1, r3, t1a, t1b, t3a, t3b, c1, c3;
      logic p1, p3, d1s, d3s;
      r1 = 0; r3 = 0; t1a = 0; t1b = 0; t3a = 0; t3b = 0; c1 = 0; c3 = 0;
      d1s = 1'b0; d3s = 1'b0;
      @(negedge clk); start_s = 1'b1;
      @(negedge clk); start_s = 1'b0;
      p1 = sck1; p3 = sck3; cyc = 1;
      while (!(d1s && d3s) && cyc < 600) begin
        if (sck1 && !p1) begin
          if (r1 == 0) t1a = cyc; else if (r1 == 1) t1b = cyc;
          r1++;
        end
        if (sck3 && !p3) begin
          if (r3 == 0) t3a = cyc; else if (r3 == 1) t3b = cyc;
          r3++;
        end
        p1 = sck1; p3 = sck3;
        if (done1 && !d1s) begin d1s = 1'b1; c1 = cyc; end
        if (done3 && !d3s) begin d3s = 1'b1; c3 = cyc; end
        @(negedge clk); cyc++;
      end
      check("div1_sck_period", t1b - t1a, 2);
      check("div3_sck_period", t3b - t3a, 6);
      check("div1_sck_rises", r1, 40);
      check("div3_sck_rises", r3, 40);
      check("div1_txn_cycles", c1, 87);
      check("div3_txn_cycles", c3, 251);
    end

    check("rd_valid_outside_cs", rv_outside, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
